seg7_hex_bank: RTL and testbench

//  Parametrised multi-digit hex display driver for the board's 7-segment HEX outputs.
//  - Accepts a NUM_DIGITS*4-bit value through a load/ready handshake.
//  - Decodes one digit per clock into a shadow buffer, then updates all digits in one cycle.
//  - Supports optional leading-zero blanking and per-digit blanking. Optional blink is compiled in by macro.
//  - Sits between counters/datapath and the HEX pins; replaces per-digit combinational decoders.

---
 rtl/seg7_hex_bank.sv | 157 +++++++++++++++
 tb/tb_seg7_hex_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_hex_bank.sv
// Multi-digit hex 7-segment driver: MSB-first scan into a shadow buffer, single-cycle commit.
// Optional blink overlay compiled in with `define SEG7_BLINK_EN.
module seg7_hex_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [NUM_DIGITS*4-1:0] value,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    ready,
  output logic [NUM_DIGITS*7-1:0] HEX
);

  localparam int W  = NUM_DIGITS * 4;
  localparam int HW = NUM_DIGITS * 7;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [W-1:0]        val_q, val_d;
  logic                lz_q, lz_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic                seen_q, seen_d;
  logic [HW-1:0]       shadow_q, shadow_d;
  logic [HW-1:0]       hex_q, hex_d;
  logic [3:0]          nib;
  logic                dark;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign nib   = val_q[idx_q*4 +: 4];
  assign ready = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    val_d    = val_q;
    lz_d     = lz_q;
    mask_d   = mask_q;
    seen_d   = seen_q;
    shadow_d = shadow_q;
    hex_d    = hex_q;
    dark     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          val_d   = value;
          lz_d    = lz_en;
          mask_d  = blank_mask;
          seen_d  = 1'b0;
          idx_d   = IW'(NUM_DIGITS - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        // digit 0 always shows, so an all-zero value still reads "0"
        dark = mask_q[idx_q] |
               (lz_q & ~seen_q & (nib == 4'h0) & (idx_q != '0));
        shadow_d[idx_q*7 +: 7] = dark ? 7'h7f : seg7(nib);
        seen_d = seen_q | (nib != 4'h0);
        if (idx_q == '0) state_d = COMMIT;
        else             idx_d   = idx_q - 1'b1;
      end
      COMMIT: begin
        hex_d   = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      val_q    <= '0;
      lz_q     <= 1'b0;
      mask_q   <= '0;
      seen_q   <= 1'b0;
      shadow_q <= '0;
      hex_q    <= '1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      lz_q     <= lz_d;
      mask_q   <= mask_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          phase_q, phase_d;
  logic          wrap;
  logic [HW-1:0] blank7;

  always_comb begin
    wrap    = (pre_q == PW'(BLINK_DIV - 1));
    pre_d   = wrap ? '0 : pre_q + 1'b1;
    phase_d = phase_q ^ wrap;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  // live overlay on the committed register; blink_mask is not latched
  always_comb begin
    blank7 = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      blank7[k*7 +: 7] = {7{blink_mask[k] & phase_q}};
  end

  assign HEX = hex_q | blank7;
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_DIV > 0);
  assign HEX = hex_q;
`endif

endmodule

// File: tb/tb_seg7_hex_bank.sv
// Randomised self-checking bench for seg7_hex_bank against a table-driven display model.
// Blink checks run only when SEG7_BLINK_EN is defined.
module tb_seg7_hex_bank;

  localparam int N  = 6;
  localparam int W  = N * 4;
  localparam int HW = N * 7;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  value;
  logic          load;
  logic          lz_en;
  logic [N-1:0]  blank_mask;
  logic [N-1:0]  blink_mask;
  logic          ready;
  logic [HW-1:0] hex;

  int n_chk  = 0;
  int n_fail = 0;

  logic [HW-1:0] cur_exp;
  logic [W-1:0]  cv;
  int            cnt;
  logic          bprev, bcur, others_ok, d0_ok;
  int            brun, bchg;

  always #5 clk = ~clk;

  seg7_hex_bank #(.NUM_DIGITS(N), .BLINK_DIV(4)) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .value     (value),
    .load      (load),
    .lz_en     (lz_en),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .ready     (ready),
    .HEX       (hex)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Digit k is lz-blanked when every nibble from k upward is zero.
  function automatic logic [HW-1:0] model(input logic [W-1:0] v,
                                          input logic lz,
                                          input logic [N-1:0] m);
    logic [HW-1:0] r;
    logic [W-1:0]  up;
    r = '1;
    for (int k = 0; k < N; k++) begin
      up = v >> (4 * k);
      if (m[k] || (lz && k != 0 && up == '0)) r[k*7 +: 7] = 7'h7f;
      else                                    r[k*7 +: 7] = SEG[up[3:0]];
    end
    return r;
  endfunction

  task automatic run_load(input string tag, input logic [W-1:0] v,
                          input logic lz, input logic [N-1:0] m,
                          input logic poke);
    int   cyc;
    logic held;
    value = v; lz_en = lz; blank_mask = m; load = 1'b1;
    tick();
    load = 1'b0;
    chk({tag, "/rdy_drop"}, 64'(ready), 64'd0);
    value = W'($urandom); lz_en = 1'($urandom);
    blank_mask = N'($urandom);
    cyc = 0; held = 1'b1;
    while (ready !== 1'b1 && cyc < 50) begin
      if (hex !== cur_exp) held = 1'b0;
      if (poke && cyc == 2) begin load = 1'b1; value = ~v; end
      else load = 1'b0;
      tick();
      cyc++;
    end
    load = 1'b0;
    chk({tag, "/latency"}, 64'(cyc), 64'(N + 1));
    chk({tag, "/hold"}, 64'(held), 64'd1);
    cur_exp = model(v, lz, m);
    chk({tag, "/hex"}, 64'(hex), 64'(cur_exp));
    if (poke) begin
      tick(); tick();
      chk({tag, "/no_queue"}, 64'(ready), 64'd1);
      chk({tag, "/hex_kept"}, 64'(hex), 64'(cur_exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; value = '0; load = 1'b0; lz_en = 1'b0;
    blank_mask = '0; blink_mask = '0;
    cur_exp = '1;
    #12;
    chk("reset/hex", 64'(hex), 64'(cur_exp));
    chk("reset/ready", 64'(ready), 64'd1);
    rst = 1'b0;
    tick();

    run_load("t2", 24'h0123AF, 1'b0, '0, 1'b0);
    chk("t2/table", 64'(hex), 64'({7'b0000001, 7'b1001111, 7'b0010010,
                                    7'b0000110, 7'b0001000, 7'b0111000}));
    run_load("t3a", 24'h00000A, 1'b1, '0, 1'b0);
    chk("t3a/table", 64'(hex), 64'({{5{7'h7f}}, 7'b0001000}));
    run_load("t3b", 24'h000000, 1'b1, '0, 1'b0);
    chk("t3b/table", 64'(hex), 64'({{5{7'h7f}}, 7'b0000001}));
    run_load("t5", 24'h111111, 1'b0, 6'b000010, 1'b0);
    chk("t5/table", 64'(hex), 64'({{4{7'b1001111}}, 7'h7f, 7'b1001111}));
    run_load("lzmask", 24'h003000, 1'b1, 6'b001000, 1'b0);
    run_load("busy", 24'h89BCDE, 1'b0, '0, 1'b1);

    for (int i = 0; i < 16; i++)
      run_load("rand", W'($urandom) >> (4 * $urandom_range(0, N)),
               1'($urandom), N'($urandom) & N'($urandom), 1'b0);

    load = 1'b1; lz_en = 1'b0; blank_mask = '0;
    value = W'($urandom);
    for (int c = 0; c < 3; c++) begin
      cv = value;
      tick();
      chk("held/cap", 64'(ready), 64'd0);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 50) begin
        value = W'($urandom);
        tick();
        cnt++;
      end
      chk("held/spacing", 64'(cnt + 1), 64'(N + 2));
      cur_exp = model(cv, 1'b0, '0);
      chk("held/hex", 64'(hex), 64'(cur_exp));
    end
    load = 1'b0;
    tick();

    value = 24'h777777; lz_en = 1'b0; blank_mask = '0; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    cur_exp = '1;
    chk("midreset/hex", 64'(hex), 64'(cur_exp));
    chk("midreset/ready", 64'(ready), 64'd1);
    #1 rst = 1'b0;
    tick();
    run_load("after_rst", 24'h5A0C3E, 1'b0, '0, 1'b0);
    run_load("last", 24'h123456, 1'b0, '0, 1'b0);

`ifdef SEG7_BLINK_EN
    blink_mask = 6'b000001;
    #1;
    bprev = (hex[6:0] == 7'h7f);
    brun = 1; bchg = 0; others_ok = 1'b1; d0_ok = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (hex[HW-1:7] !== cur_exp[HW-1:7]) others_ok = 1'b0;
      if (hex[6:0] !== cur_exp[6:0] && hex[6:0] !== 7'h7f) d0_ok = 1'b0;
      bcur = (hex[6:0] == 7'h7f);
      if (bcur != bprev) begin
        if (bchg > 0) chk("blink/run", 64'(brun), 64'd4);
        bchg++;
        brun = 1;
      end else begin
        brun++;
      end
      bprev = bcur;
    end
    chk("blink/toggles", 64'(bchg >= 4), 64'd1);
    chk("blink/others", 64'(others_ok), 64'd1);
    chk("blink/d0vals", 64'(d0_ok), 64'd1);
    blink_mask = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
